seq_shifter: RTL and testbench
==============================

Name: seq_shifter

Overview:
- Parametrised multi-cycle shifter for the datapath ALU/shift stage.
- Successor to the fixed 1-bit, 16-bit shifter: variable shift amount, configurable width and bits-per-cycle, carry-out and zero flags.
- Uses a valid/ready handshake on both sides so the controller FSM can stall on it.

Parameters:
- WIDTH, 16: datapath width in bits (>= 2).
- STEP, 1: maximum bit positions shifted per clock (1..WIDTH).
- AMT_W, $clog2(WIDTH)+1: width of the shift-amount field, so the value WIDTH is representable.

Ports:
- clk  in  1  clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  request valid.
- in_ready  out  1  block can accept a request.
- din  in  WIDTH  operand.
- op  in  3  000 pass, 001 LSL, 010 LSR, 011 ASR, 100 ROR (only with the macro), others pass.
- amt  in  AMT_W  shift amount.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- dout  out  WIDTH  result.
- carry  out  1  last bit shifted out; 0 for pass or amt=0.
- zero  out  1  dout == 0.

Behaviour:
- Reset (async assert, synchronous-safe release):
  - state=IDLE; dout, carry, zero, out_valid = 0; in_ready = 1.
  - Reset mid-shift aborts immediately; the partial result is discarded.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid: latch din, op and rem = min(amt, WIDTH); clear carry.
  - Go to DONE if rem == 0 or op is pass, else go to SHIFT.
- SHIFT:
  - in_ready = 0.
  - Each cycle shift by s = min(STEP, rem) and set rem -= s.
  - carry = the last bit shifted out of the shift just performed.
  - Fill: LSL 0 from the right; LSR 0 from the left; ASR replicates the MSB; ROR wraps bits.
  - When rem reaches 0 after an update, go to DONE.
- DONE:
  - out_valid = 1; dout, carry and zero are stable.
  - On out_ready go to IDLE; out_valid drops the next cycle.
  - With out_ready low, outputs hold indefinitely.
- Latency: request accepted at edge k -> out_valid high from edge k+1+ceil(rem/STEP).
  - amt=0 or pass: out_valid at edge k+1.
- No overlap: a new request is accepted only in IDLE. Throughput is one result per (latency+1) cycles minimum.
- Clamping: amt > WIDTH is treated as WIDTH.
  - LSL by WIDTH -> 0, carry=din[0].
  - LSR by WIDTH -> 0, carry=din[WIDTH-1].
  - ASR by WIDTH -> all sign bits, carry=sign.
  - ROR by WIDTH -> din, carry=din[WIDTH-1].
- zero is registered together with dout.
- in_valid while not in IDLE is ignored; the upstream stage holds it.

Optional Feature:
- Macro SEQ_SHIFTER_ROTATE_EN.
- Defined: op 100 performs rotate right by amt. Bits leaving the LSB enter at the MSB; carry = the last bit rotated out.
- Undefined: no rotate logic is built; op 100 behaves as pass (dout=din, carry=0, 1-cycle latency).

Decomposition:
- Shared package seq_shift_pkg holds:
  - Op encodings: OP_PASS, OP_LSL, OP_LSR, OP_ASR, OP_ROR.
  - State encodings: S_IDLE, S_SHIFT, S_DONE.
- One combinational sub-module, shift_step: performs a single shift of up to STEP bits with the fill rule and carry extraction.
- seq_shifter contains the FSM, rem counter and registers, and instantiates shift_step once.

Test Plan:
- WIDTH=16, STEP=1, din=16'hF0CF, LSL, amt=1 -> dout=16'b1110000110011110, carry=1, out_valid at k+2.
- din=16'hF0CF, LSR, amt=4 -> dout=16'h0F0C, carry=1, zero=0, out_valid at k+5. Repeat with STEP=4 -> same result, out_valid at k+2.
- din=16'hF0CF, ASR, amt=20 (clamped) -> dout=16'hFFFF, carry=1. Same with amt=0 -> dout=16'hF0CF, carry=0, out_valid at k+1.
- din=16'h8000, LSL, amt=1 -> dout=0, zero=1, carry=1. Hold out_ready low 5 cycles -> outputs stable and in_ready=0 throughout; release -> IDLE next cycle.
- Macro defined: din=16'hF0CF, ROR, amt=4 -> dout=16'hFF0C, carry=1. Macro undefined -> dout=16'hF0CF, carry=0.
- Assert reset_n=0 mid-SHIFT (LSR amt=8, after 3 cycles) -> asynchronous return to IDLE with all outputs 0. A new request afterwards completes correctly.

Source files
------------

// File: rtl/seq_shift_pkg.sv
// Shared encodings for the multi-cycle shifter.
// SEQ_SHIFTER_ROTATE_EN: when defined, OP_ROR counts as a real shift;
// otherwise it falls through to pass.
package seq_shift_pkg;

    typedef enum logic [2:0] {
        OP_PASS = 3'b000,
        OP_LSL  = 3'b001,
        OP_LSR  = 3'b010,
        OP_ASR  = 3'b011,
        OP_ROR  = 3'b100
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_e;

    // True when the opcode needs the SHIFT state; everything else is pass.
    function automatic logic op_is_shift(input logic [2:0] op);
        logic r;
        r = (op == OP_LSL) || (op == OP_LSR) || (op == OP_ASR);
`ifdef SEQ_SHIFTER_ROTATE_EN
        r = r || (op == OP_ROR);
`endif
        return r;
    endfunction

endpackage

// File: rtl/shift_step.sv
// One combinational shift of i_s bit positions (1..STEP) with fill and
// carry extraction. i_s == 0 passes data through with carry 0.
// SEQ_SHIFTER_ROTATE_EN: builds the rotate-right path.
module shift_step
    import seq_shift_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int AMT_W = $clog2(WIDTH) + 1
) (
    input  logic [WIDTH-1:0] i_data,
    input  logic [2:0]       i_op,
    input  logic [AMT_W-1:0] i_s,
    output logic [WIDTH-1:0] o_data,
    output logic             o_carry
);

`ifdef SEQ_SHIFTER_ROTATE_EN
    localparam logic [AMT_W-1:0] W_AMT = AMT_W'(WIDTH);
`endif

    // Shifting by s-1 puts the last bit to leave at the edge, which avoids
    // variable bit-select indexing for the carry.
    logic [AMT_W-1:0] w_sm1;
    logic [WIDTH-1:0] w_lsl_pre;
    logic [WIDTH-1:0] w_rsh_pre;

    assign w_sm1     = i_s - AMT_W'(1);
    assign w_lsl_pre = i_data << w_sm1;
    assign w_rsh_pre = i_data >> w_sm1;

    // Select result and carry according to the operation.
    always_comb begin
        o_data  = i_data;
        o_carry = 1'b0;
        if (i_s != '0) begin
            case (i_op)
                OP_LSL: begin
                    o_data  = i_data << i_s;
                    o_carry = w_lsl_pre[WIDTH-1];
                end
                OP_LSR: begin
                    o_data  = i_data >> i_s;
                    o_carry = w_rsh_pre[0];
                end
                OP_ASR: begin
                    o_data  = $signed(i_data) >>> i_s;
                    o_carry = w_rsh_pre[0];
                end
`ifdef SEQ_SHIFTER_ROTATE_EN
                OP_ROR: begin
                    // s == WIDTH gives a left shift by 0, i.e. the full word.
                    o_data  = (i_data >> i_s) | (i_data << (W_AMT - i_s));
                    o_carry = w_rsh_pre[0];
                end
`endif
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/seq_shifter.sv
// Multi-cycle shifter with valid/ready on both sides: IDLE latches the
// request, SHIFT moves up to STEP bits per clock, DONE holds the result
// until out_ready.
// SEQ_SHIFTER_ROTATE_EN: enables op 100 (rotate right); otherwise pass.
module seq_shifter
    import seq_shift_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int STEP  = 1,
    parameter int AMT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] din,
    input  logic [2:0]       op,
    input  logic [AMT_W-1:0] amt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] dout,
    output logic             carry,
    output logic             zero
);

    localparam logic [AMT_W-1:0] W_AMT  = AMT_W'(WIDTH);
    localparam logic [AMT_W-1:0] STEP_A = AMT_W'(STEP);

    state_e           r_state;
    state_e           w_state_nxt;
    logic [2:0]       r_op;
    logic [AMT_W-1:0] r_rem;
    logic [WIDTH-1:0] r_dout;
    logic             r_carry;
    logic             r_zero;

    logic [AMT_W-1:0] w_amt_cl;
    logic [AMT_W-1:0] w_s;
    logic [AMT_W-1:0] w_rem_nxt;
    logic [WIDTH-1:0] w_step_data;
    logic             w_step_carry;

    assign w_amt_cl  = (amt > W_AMT) ? W_AMT : amt;
    assign w_s       = (r_rem > STEP_A) ? STEP_A : r_rem;
    assign w_rem_nxt = r_rem - w_s;

    shift_step #(
        .WIDTH (WIDTH),
        .AMT_W (AMT_W)
    ) u_step (
        .i_data  (r_dout),
        .i_op    (r_op),
        .i_s     (w_s),
        .o_data  (w_step_data),
        .o_carry (w_step_carry)
    );

    // State register; reset aborts any shift in progress.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= S_IDLE;
        else          r_state <= w_state_nxt;
    end

    // Next-state and handshake outputs.
    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    if (w_amt_cl == '0 || !op_is_shift(op)) w_state_nxt = S_DONE;
                    else                                    w_state_nxt = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (w_rem_nxt == '0) w_state_nxt = S_DONE;
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Working register doubles as the result; zero tracks it each update.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_op    <= OP_PASS;
            r_rem   <= '0;
            r_dout  <= '0;
            r_carry <= 1'b0;
            r_zero  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: if (in_valid) begin
                    r_op    <= op;
                    r_rem   <= w_amt_cl;
                    r_dout  <= din;
                    r_carry <= 1'b0;
                    r_zero  <= (din == '0);
                end
                S_SHIFT: begin
                    r_rem   <= w_rem_nxt;
                    r_dout  <= w_step_data;
                    r_carry <= w_step_carry;
                    r_zero  <= (w_step_data == '0);
                end
                default: ;
            endcase
        end
    end

    assign dout  = r_dout;
    assign carry = r_carry;
    assign zero  = r_zero;

endmodule

// File: tb/tb_seq_shifter.sv
// Bench for seq_shifter: two instances (STEP=1 and STEP=4) share stimulus
// and are checked against an arithmetic reference model.
module tb_seq_shifter;

    localparam int W  = 16;
    localparam int AW = $clog2(W) + 1;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          out_ready = 1'b0;
    logic [W-1:0]  din = '0;
    logic [2:0]    op = '0;
    logic [AW-1:0] amt = '0;
    logic [1:0]    in_ready, out_valid, carry, zero;
    logic [W-1:0]  dout [2];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    seq_shifter #(.WIDTH(W), .STEP(1)) u_s1 (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready[0]),
        .din(din), .op(op), .amt(amt), .out_valid(out_valid[0]), .out_ready(out_ready),
        .dout(dout[0]), .carry(carry[0]), .zero(zero[0]));

    seq_shifter #(.WIDTH(W), .STEP(4)) u_s4 (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready[1]),
        .din(din), .op(op), .amt(amt), .out_valid(out_valid[1]), .out_ready(out_ready),
        .dout(dout[1]), .carry(carry[1]), .zero(zero[1]));

    function automatic int step_of(input int i);
        return (i == 0) ? 1 : 4;
    endfunction

    // Reference: result of shifting din by min(amt,W) in one go.
    task automatic model(input logic [W-1:0] d, input logic [2:0] o, input int a,
                         input int st, output logic [W-1:0] ed, output logic ec,
                         output int lat);
        int n;
        bit sh;
        n  = (a > W) ? W : a;
        sh = (o == 3'd1) || (o == 3'd2) || (o == 3'd3);
`ifdef SEQ_SHIFTER_ROTATE_EN
        if (o == 3'd4) sh = 1'b1;
`endif
        ed  = d;
        ec  = 1'b0;
        lat = 1;
        if (sh && n > 0) begin
            lat = 1 + (n + st - 1) / st;
            ec  = d[n-1];
            case (o)
                3'd1: begin
                    ed = (n == W) ? '0 : (d << n);
                    ec = d[W-n];
                end
                3'd2: ed = d >> n;
                3'd3: ed = $signed(d) >>> n;
                default: ed = (n == W) ? d : ((d >> n) | (d << (W - n)));
            endcase
        end
    endtask

    // Issue one request to both instances, check latency and result,
    // then consume it. With junk set, in_valid stays high with other data
    // while the block is busy and must be ignored.
    task automatic run_req(input logic [W-1:0] d, input logic [2:0] o,
                           input int a, input bit junk);
        logic [W-1:0] ed [2];
        logic         ec [2];
        int           el [2];
        int           got [2];
        int           cyc;
        for (int i = 0; i < 2; i++) model(d, o, a, step_of(i), ed[i], ec[i], el[i]);
        @(negedge clk);
        n_tests++;
        if (in_ready !== 2'b11) begin
            n_fail++;
            $display("FAIL idle_in_ready: got %b want 11", in_ready);
        end
        din = d; op = o; amt = AW'(a); in_valid = 1'b1;
        @(negedge clk);
        cyc = 1;
        if (junk) begin
            din = ~d; op = 3'($urandom); amt = AW'($urandom_range(0, 20));
        end else begin
            in_valid = 1'b0;
        end
        got[0] = -1; got[1] = -1;
        forever begin
            for (int i = 0; i < 2; i++)
                if (got[i] < 0 && out_valid[i]) got[i] = cyc;
            if ((got[0] >= 0 && got[1] >= 0) || cyc >= 100) break;
            @(negedge clk);
            cyc++;
        end
        in_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            n_tests++;
            if (got[i] !== el[i]) begin
                n_fail++;
                $display("FAIL latency step%0d d=%h op=%0d amt=%0d: got %0d want %0d",
                         step_of(i), d, o, a, got[i], el[i]);
            end
            n_tests++;
            if (dout[i] !== ed[i]) begin
                n_fail++;
                $display("FAIL dout step%0d d=%h op=%0d amt=%0d: got %h want %h",
                         step_of(i), d, o, a, dout[i], ed[i]);
            end
            n_tests++;
            if (carry[i] !== ec[i]) begin
                n_fail++;
                $display("FAIL carry step%0d d=%h op=%0d amt=%0d: got %b want %b",
                         step_of(i), d, o, a, carry[i], ec[i]);
            end
            n_tests++;
            if (zero[i] !== (ed[i] == '0)) begin
                n_fail++;
                $display("FAIL zero step%0d d=%h op=%0d amt=%0d: got %b want %b",
                         step_of(i), d, o, a, zero[i], (ed[i] == '0));
            end
        end
        n_tests++;
        if (in_ready !== 2'b00) begin
            n_fail++;
            $display("FAIL done_in_ready: got %b want 00", in_ready);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        n_tests++;
        if (out_valid !== 2'b00 || in_ready !== 2'b11) begin
            n_fail++;
            $display("FAIL release: got out_valid=%b in_ready=%b want 00/11", out_valid, in_ready);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        n_tests++;
        if (in_ready !== 2'b11 || out_valid !== 2'b00 || carry !== 2'b00 || zero !== 2'b00 ||
            dout[0] !== '0 || dout[1] !== '0) begin
            n_fail++;
            $display("FAIL reset_state: got rdy=%b vld=%b c=%b z=%b d=%h/%h want 11/00/00/00/0",
                     in_ready, out_valid, carry, zero, dout[0], dout[1]);
        end
        reset_n = 1'b1;
    endtask

    task automatic test_directed();
        run_req(16'hF0CF, 3'd1, 1, 1'b0);
        run_req(16'hF0CF, 3'd2, 4, 1'b0);
        run_req(16'hF0CF, 3'd3, 20, 1'b0);
        run_req(16'hF0CF, 3'd3, 0, 1'b0);
        run_req(16'h8000, 3'd1, 1, 1'b0);
        run_req(16'hF0CF, 3'd4, 4, 1'b0);
        run_req(16'h1234, 3'd1, 16, 1'b0);
        run_req(16'h1234, 3'd2, 16, 1'b0);
        run_req(16'h8001, 3'd4, 16, 1'b0);
        run_req(16'h00F0, 3'd7, 5, 1'b0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++)
            run_req(W'($urandom), 3'($urandom_range(0, 7)), $urandom_range(0, 20), i[0]);
    endtask

    task automatic test_hold();
        int cyc;
        @(negedge clk);
        din = 16'h8000; op = 3'd1; amt = AW'(1); in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        cyc = 0;
        while (out_valid !== 2'b11 && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        for (int k = 0; k < 5; k++) begin
            n_tests++;
            if (out_valid !== 2'b11 || in_ready !== 2'b00 || carry !== 2'b11 ||
                zero !== 2'b11 || dout[0] !== '0 || dout[1] !== '0) begin
                n_fail++;
                $display("FAIL hold cyc%0d: got vld=%b rdy=%b c=%b z=%b d=%h/%h want 11/00/11/11/0",
                         k, out_valid, in_ready, carry, zero, dout[0], dout[1]);
            end
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        n_tests++;
        if (in_ready !== 2'b11 || out_valid !== 2'b00) begin
            n_fail++;
            $display("FAIL hold_release: got rdy=%b vld=%b want 11/00", in_ready, out_valid);
        end
    endtask

    task automatic test_reset_mid_shift();
        @(negedge clk);
        din = 16'hF0CF; op = 3'd2; amt = AW'(8); in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        n_tests++;
        if (out_valid[0] !== 1'b0 || in_ready[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_shift_busy: got vld=%b rdy=%b want 0/0", out_valid[0], in_ready[0]);
        end
        reset_n = 1'b0;
        #1;
        n_tests++;
        if (in_ready !== 2'b11 || out_valid !== 2'b00 || carry !== 2'b00 || zero !== 2'b00 ||
            dout[0] !== '0 || dout[1] !== '0) begin
            n_fail++;
            $display("FAIL async_reset: got rdy=%b vld=%b c=%b z=%b d=%h/%h want 11/00/00/00/0",
                     in_ready, out_valid, carry, zero, dout[0], dout[1]);
        end
        @(negedge clk);
        reset_n = 1'b1;
        run_req(16'hF0CF, 3'd2, 8, 1'b0);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_hold();
        test_random();
        test_reset_mid_shift();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
